adc_capture: RTL and testbench

- Runs in the 40 MHz PLL output domain and takes the PLL's `locked` signal.
- Qualifies lock, registers the parallel ADC bus, and on an `arm` pulse captures a programmable number of optionally decimated samples into an on-chip buffer.
- Drains the buffer as a valid/ready stream toward the host interface.
- Loss of lock aborts everything and re-qualifies.

---
 rtl/adc_pkg.sv | 19 +
 rtl/adc_capture_ram.sv | 24 ++
 rtl/adc_capture.sv | 161 ++++++++++++++++
 tb/tb_adc_capture.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared definitions for the ADC capture path and the host-interface block.
package adc_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    IDLE      = 2'd1,
    CAPTURE   = 2'd2,
    DRAIN     = 2'd3
  } cap_state_e;

  localparam int ADC_DATA_W = 10;
  localparam int ADC_DEPTH  = 256;

  // A zero or oversized request selects a full buffer.
  function automatic int unsigned eff_len(input int unsigned req, input int unsigned depth);
    return (req == 0 || req > depth) ? depth : req;
  endfunction

endpackage

// File: rtl/adc_capture_ram.sv
// Simple dual-port sample buffer with a registered read port, shaped for
// block-RAM inference (no reset on the array or the read register).
module capture_ram #(
  parameter  int WIDTH = 11,
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_o <= mem[rd_addr_i];
  end

endmodule

// File: rtl/adc_capture.sv
// Lock-qualified ADC snapshot: captures N (optionally decimated) samples on arm,
// then drains them as a valid/ready stream with a one-entry skid register.
module adc_capture
  import adc_pkg::*;
#(
  parameter  int DATA_W    = ADC_DATA_W,
  parameter  int DEPTH     = ADC_DEPTH,
  parameter  int LOCK_WAIT = 1023,
  parameter  int DECIM_W   = 8,
  localparam int AW        = $clog2(DEPTH),
  localparam int LW        = AW + 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               pll_locked,
  input  logic [DATA_W-1:0]  adc_data,
  input  logic               adc_ovr,
  input  logic               arm,
  input  logic [DECIM_W-1:0] decim,
  input  logic [LW-1:0]      num_samples,
  output logic [DATA_W:0]    out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               lock_ok,
  output logic               busy,
  output logic               ovr_seen
);

  localparam int CW = $clog2(LOCK_WAIT + 1);

  logic              lock_meta_q, lock_sync_q, lock_ok_q;
  logic [CW-1:0]     lock_cnt_q;
  logic [DATA_W:0]   adc_q;
  cap_state_e        state_q;
  logic [DECIM_W-1:0] decim_q, dec_cnt_q;
  logic [LW-1:0]     len_q, wr_cnt_q, issue_cnt_q;
  logic              pend_q, pend_last_q;
  logic [DATA_W:0]   out_q, skid_q, rd_data;
  logic              out_valid_q, out_last_q, skid_valid_q, skid_last_q;
  logic              ovr_seen_q;
  logic              wr_en, rd_en, pop;
  logic [1:0]        fill;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
      lock_cnt_q  <= '0;
      lock_ok_q   <= 1'b0;
      adc_q       <= '0;
    end else begin
      lock_meta_q <= pll_locked;
      lock_sync_q <= lock_meta_q;
      if (!lock_sync_q)                   lock_cnt_q <= '0;
      else if (lock_cnt_q != CW'(LOCK_WAIT)) lock_cnt_q <= lock_cnt_q + CW'(1);
      lock_ok_q <= lock_sync_q && (lock_cnt_q == CW'(LOCK_WAIT));
      adc_q     <= {adc_ovr, adc_data};
    end
  end

  assign wr_en = (state_q == CAPTURE) && (dec_cnt_q == '0);
  assign pop   = out_valid_q & out_ready;
  // Entries held or in flight after this cycle; a read is issued only if it has a slot.
  assign fill  = {1'b0, out_valid_q} + {1'b0, skid_valid_q} + {1'b0, pend_q} - {1'b0, pop};
  assign rd_en = (state_q == DRAIN) && (issue_cnt_q != len_q) && (fill < 2'd2);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= WAIT_LOCK;
      decim_q      <= '0;
      dec_cnt_q    <= '0;
      len_q        <= '0;
      wr_cnt_q     <= '0;
      issue_cnt_q  <= '0;
      pend_q       <= 1'b0;
      pend_last_q  <= 1'b0;
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      skid_last_q  <= 1'b0;
      ovr_seen_q   <= 1'b0;
    end else if (!lock_sync_q) begin
      state_q      <= WAIT_LOCK;
      dec_cnt_q    <= '0;
      wr_cnt_q     <= '0;
      issue_cnt_q  <= '0;
      pend_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      pend_q <= rd_en;
      if (rd_en) begin
        pend_last_q <= (issue_cnt_q == len_q - LW'(1));
        issue_cnt_q <= issue_cnt_q + LW'(1);
      end
      case (state_q)
        WAIT_LOCK: if (lock_ok_q) state_q <= IDLE;
        IDLE: if (arm) begin
          state_q     <= CAPTURE;
          decim_q     <= decim;
          len_q       <= LW'(eff_len(32'(num_samples), DEPTH));
          dec_cnt_q   <= '0;
          wr_cnt_q    <= '0;
          issue_cnt_q <= '0;
          ovr_seen_q  <= 1'b0;
        end
        CAPTURE: begin
          dec_cnt_q <= (dec_cnt_q == decim_q) ? '0 : dec_cnt_q + DECIM_W'(1);
          if (wr_en) begin
            wr_cnt_q <= wr_cnt_q + LW'(1);
            if (adc_q[DATA_W]) ovr_seen_q <= 1'b1;
            if (wr_cnt_q + LW'(1) == len_q) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (!out_valid_q || out_ready) begin
            if (skid_valid_q) begin
              out_q        <= skid_q;
              out_last_q   <= skid_last_q;
              out_valid_q  <= 1'b1;
              skid_q       <= rd_data;
              skid_last_q  <= pend_last_q;
              skid_valid_q <= pend_q;
            end else begin
              out_q       <= rd_data;
              out_last_q  <= pend_q & pend_last_q;
              out_valid_q <= pend_q;
            end
          end else if (pend_q) begin
            skid_q       <= rd_data;
            skid_last_q  <= pend_last_q;
            skid_valid_q <= 1'b1;
          end
          if (pop && out_last_q) state_q <= IDLE;
        end
      endcase
    end
  end

  capture_ram #(.WIDTH(DATA_W + 1), .DEPTH(DEPTH)) u_ram (
    .clock     (clock),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_cnt_q[AW-1:0]),
    .wr_data_i (adc_q),
    .rd_en_i   (rd_en),
    .rd_addr_i (issue_cnt_q[AW-1:0]),
    .rd_data_o (rd_data)
  );

  assign out_data  = out_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign lock_ok   = lock_ok_q;
  assign busy      = (state_q == CAPTURE) || (state_q == DRAIN);
  assign ovr_seen  = ovr_seen_q;

endmodule

// File: tb/tb_adc_capture.sv
// Scoreboard bench for adc_capture: stimulus pushes expected {ovr,sample,last}
// entries, a negedge monitor checks every presented word against the queue head.
module tb_adc_capture;
  import adc_pkg::*;

  localparam int DATA_W    = ADC_DATA_W;
  localparam int DEPTH     = ADC_DEPTH;
  localparam int LOCK_WAIT = 1023;
  localparam int DECIM_W   = 8;
  localparam int LW        = $clog2(DEPTH) + 1;

  logic               clock = 1'b0;
  logic               reset_n = 1'b0;
  logic               pll_locked = 1'b0;
  logic [DATA_W-1:0]  adc_data = '0;
  logic               adc_ovr = 1'b0;
  logic               arm = 1'b0;
  logic [DECIM_W-1:0] decim = '0;
  logic [LW-1:0]      num_samples = '0;
  logic               out_ready = 1'b1;
  logic [DATA_W:0]    out_data;
  logic               out_valid, out_last, lock_ok, busy, ovr_seen;

  adc_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LOCK_WAIT(LOCK_WAIT), .DECIM_W(DECIM_W)) dut (
    .clock(clock), .reset_n(reset_n), .pll_locked(pll_locked),
    .adc_data(adc_data), .adc_ovr(adc_ovr), .arm(arm), .decim(decim),
    .num_samples(num_samples), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .lock_ok(lock_ok),
    .busy(busy), .ovr_seen(ovr_seen)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [DATA_W:0] d;
    logic            last;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;
  int   xfer_cnt = 0;
  int   last_cnt = 0;
  int   ramp = 0;
  int   ovr_at = -1;
  bit   bp_mode = 1'b0;
  bit   pat [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

  // Free-running ADC ramp with an optional overflow pulse on one code.
  initial forever begin
    @(posedge clock);
    #1;
    ramp     = (ramp + 1) % 1024;
    adc_data = DATA_W'(ramp);
    adc_ovr  = (ovr_at >= 0) && (ramp == ovr_at);
  end

  initial begin : ready_drv
    int pi;
    pi = 0;
    forever begin
      @(posedge clock);
      #1;
      if (bp_mode) begin
        out_ready = pat[pi % 8];
        pi++;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  initial forever begin
    @(negedge clock);
    if (reset_n && out_valid) begin
      checks++;
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output got=%h last=%b required=none", out_data, out_last);
      end else begin
        if (out_data !== sbq[0].d || out_last !== sbq[0].last) begin
          failures++;
          $display("FAIL stream_word got=%h last=%b required=%h last=%b",
                   out_data, out_last, sbq[0].d, sbq[0].last);
        end
        if (out_ready) begin
          void'(sbq.pop_front());
          xfer_cnt++;
          if (out_last) last_cnt++;
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  task automatic push(input int val, input bit ovr, input bit last);
    exp_t e;
    e.d    = {ovr, DATA_W'(val)};
    e.last = last;
    sbq.push_back(e);
  endtask

  task automatic push_run(input int v, input int d, input int n);
    for (int k = 0; k < n; k++) begin
      int x;
      x = (v + k * (d + 1)) % 1024;
      push(x, (ovr_at >= 0) && (x == ovr_at), k == n - 1);
    end
  endtask

  task automatic pulse_arm(input int d, input int n);
    decim       = DECIM_W'(d);
    num_samples = LW'(n);
    arm         = 1'b1;
    @(posedge clock);
    #2;
    arm = 1'b0;
  endtask

  // Arm in the cycle whose registered sample will be v.
  task automatic arm_when(input int v, input int d, input int n);
    int i;
    for (i = 0; i < 2100; i++) begin
      if (int'(adc_data) == v) break;
      @(posedge clock);
      #2;
    end
    if (i == 2100) begin
      failures++;
      $display("FAIL arm_wait got=timeout required=ramp_%0d", v);
    end
    pulse_arm(d, n);
  endtask

  task automatic wait_done(input string name, input int limit);
    int i;
    for (i = 0; i < limit; i++) begin
      @(posedge clock);
      #2;
      if (sbq.size() == 0 && !busy) break;
    end
    checks++;
    if (i == limit) begin
      failures++;
      $display("FAIL %s_done got=pending_%0d required=0", name, sbq.size());
    end
  endtask

  task automatic wait_lock(input int limit);
    int i;
    for (i = 0; i < limit; i++) begin
      @(posedge clock);
      #2;
      if (lock_ok) break;
    end
    check("relock", int'(lock_ok), 1);
  endtask

  initial begin : stim
    int n, x0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_lock_ok", int'(lock_ok), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ovr_seen", int'(ovr_seen), 0);
    check("rst_last_data", int'({out_last, out_data}), 0);
    @(posedge clock);
    #2;
    reset_n = 1'b1;

    // Lock with a one-cycle glitch just before qualification would complete.
    pll_locked = 1'b1;
    repeat (100) @(posedge clock);
    #2;
    pulse_arm(0, 4);
    repeat (5) @(posedge clock);
    @(negedge clock);
    check("arm_in_wait_lock_busy", int'(busy), 0);
    repeat (LOCK_WAIT - 10 - 106) @(posedge clock);
    #2;
    pll_locked = 1'b0;
    @(posedge clock);
    #2;
    pll_locked = 1'b1;
    n = 0;
    while (n < 1100) begin
      @(posedge clock);
      n++;
      @(negedge clock);
      if (lock_ok) break;
    end
    checks++;
    if (n < LOCK_WAIT + 1 || n > LOCK_WAIT + 4) begin
      failures++;
      $display("FAIL lock_qual_cycles got=%0d required=%0d..%0d", n, LOCK_WAIT + 1, LOCK_WAIT + 4);
    end
    repeat (2) @(posedge clock);
    #2;

    x0 = xfer_cnt;
    push(100, 0, 0); push(101, 0, 0); push(102, 0, 0); push(103, 0, 1);
    arm_when(100, 0, 4);
    wait_done("basic", 200);
    check("basic_xfers", xfer_cnt - x0, 4);
    check("basic_busy", int'(busy), 0);
    check("basic_ovr_seen", int'(ovr_seen), 0);

    ovr_at = 53;
    x0 = xfer_cnt;
    push(50, 0, 0); push(53, 1, 0); push(56, 0, 1);
    arm_when(50, 2, 3);
    wait_done("decim", 200);
    check("decim_xfers", xfer_cnt - x0, 3);
    check("decim_ovr_seen", int'(ovr_seen), 1);
    ovr_at = -1;

    bp_mode = 1'b1;
    x0 = xfer_cnt;
    push_run(200, 0, 8);
    arm_when(200, 0, 8);
    wait_done("backpressure", 400);
    bp_mode = 1'b0;
    check("bp_xfers", xfer_cnt - x0, 8);
    check("bp_ovr_cleared", int'(ovr_seen), 0);

    x0 = xfer_cnt;
    push_run(300, 0, DEPTH);
    arm_when(300, 0, 0);
    wait_done("len_zero", 2000);
    check("len_zero_xfers", xfer_cnt - x0, DEPTH);

    x0 = xfer_cnt;
    push_run(600, 0, DEPTH);
    arm_when(600, 0, 300);
    wait_done("len_300", 2000);
    check("len_300_xfers", xfer_cnt - x0, DEPTH);

    x0 = xfer_cnt;
    push_run(400, 0, 8);
    arm_when(400, 0, 8);
    for (int i = 0; i < 100 && !out_valid; i++) begin
      @(posedge clock);
      #2;
    end
    pulse_arm(0, 4);
    wait_done("arm_busy", 400);
    repeat (20) @(posedge clock);
    #2;
    check("arm_busy_xfers", xfer_cnt - x0, 8);
    check("arm_busy_idle", int'(busy), 0);

    // Lose lock after five writes of a 16-sample capture; nothing may be streamed.
    ovr_at = 702;
    arm_when(700, 0, 16);
    repeat (5) @(posedge clock);
    #2;
    pll_locked = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("loss_valid", int'(out_valid), 0);
    check("loss_busy", int'(busy), 0);
    check("loss_lock_ok", int'(lock_ok), 0);
    check("loss_ovr_held", int'(ovr_seen), 1);
    repeat (20) @(posedge clock);
    #2;
    check("loss_still_idle", int'(busy), 0);
    pll_locked = 1'b1;
    ovr_at = -1;
    wait_lock(1200);
    repeat (2) @(posedge clock);
    #2;
    x0 = xfer_cnt;
    push_run(120, 0, 5);
    arm_when(120, 0, 5);
    wait_done("relock_capture", 200);
    check("relock_xfers", xfer_cnt - x0, 5);
    check("relock_ovr_cleared", int'(ovr_seen), 0);
    check("total_last_count", last_cnt, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
